// File: rtl/rex_jump_ctrl.sv
// rex_jump_ctrl: debounced jump button and frame-stepped jump FSM for the dino sprite.
// Optional feature: define DOUBLE_JUMP_EN to allow one extra jump per airborne period.
module rex_jump_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1200,
  parameter int JUMP_HEIGHT     = 12,
  parameter int HOVER_FRAMES    = 2
) (
  input  logic       clk_120kHz,
  input  logic       rstn,
  input  logic       clk_12Hz,
  input  logic       btn_jump,
  input  logic       game_over,
  output logic       frame_tick,
  output logic [4:0] dino_y,
  output logic       jumping
);
  typedef enum logic [2:0] {GROUND, RISE, HOVER, FALL, DEAD} state_t;
  localparam int HW = $clog2(HOVER_FRAMES + 1);
  logic [1:0]    s12_q, btn_s_q;
  logic          s12_prev_q, tick_q, acc_q, jump_req_q, jumping_q;
  logic [10:0]   db_cnt_q;
  logic [HW-1:0] hov_q;
  logic [4:0]    y_q, lim, dn;
  logic [5:0]    up;
  logic          btn_s, db_diff, db_done, press;
  state_t        state_q;
`ifdef DOUBLE_JUMP_EN
  localparam int LIM2 = (2 * JUMP_HEIGHT < 30) ? 2 * JUMP_HEIGHT : 30;
  logic [4:0] lim_q;
  logic       dj_used_q;
  assign lim = lim_q;
`else
  assign lim = 5'(JUMP_HEIGHT);
`endif
  assign btn_s      = btn_s_q[1];
  assign db_diff    = btn_s != acc_q;
  assign db_done    = db_diff && db_cnt_q == 11'(DEBOUNCE_CYCLES - 1);
  assign press      = db_done && btn_s;
  assign up         = {1'b0, y_q} + 6'd2;
  assign dn         = (y_q <= 5'd2) ? 5'd0 : y_q - 5'd2;
  assign frame_tick = tick_q;
  assign dino_y     = y_q;
  assign jumping    = jumping_q;
  // Synchronize the frame clock and button, and pulse once per frame-clock rising edge.
  always_ff @(posedge clk_120kHz or negedge rstn) begin
    if (!rstn) begin
      s12_q      <= '0;
      btn_s_q    <= '0;
      s12_prev_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      s12_q      <= {s12_q[0], clk_12Hz};
      btn_s_q    <= {btn_s_q[0], btn_jump};
      s12_prev_q <= s12_q[1];
      tick_q     <= s12_q[1] & ~s12_prev_q;
    end
  end
  // Accept a new button level only after it has differed for the full debounce window.
  always_ff @(posedge clk_120kHz or negedge rstn) begin
    if (!rstn) begin
      db_cnt_q <= '0;
      acc_q    <= 1'b0;
    end else begin
      db_cnt_q <= (db_diff && !db_done) ? db_cnt_q + 11'd1 : 11'd0;
      acc_q    <= db_done ? btn_s : acc_q;
    end
  end
  // Latch one jump request per accepted press; it expires at the next frame tick.
  always_ff @(posedge clk_120kHz or negedge rstn) begin
    if (!rstn) jump_req_q <= 1'b0;
    else jump_req_q <= (press & ~(tick_q & state_q == DEAD & ~game_over)) | (jump_req_q & ~tick_q);
  end
  // Jump state machine: collision forces DEAD at once, everything else steps on frame ticks.
  always_ff @(posedge clk_120kHz or negedge rstn) begin
    if (!rstn) begin
      state_q   <= GROUND;
      y_q       <= '0;
      jumping_q <= 1'b0;
      hov_q     <= '0;
`ifdef DOUBLE_JUMP_EN
      lim_q     <= 5'(JUMP_HEIGHT);
      dj_used_q <= 1'b0;
`endif
    end else if (game_over) begin
      state_q   <= DEAD;
      jumping_q <= 1'b0;
    end else if (tick_q) begin
      case (state_q)
        GROUND: begin
`ifdef DOUBLE_JUMP_EN
          lim_q     <= 5'(JUMP_HEIGHT);
          dj_used_q <= 1'b0;
`endif
          if (jump_req_q) begin
            state_q   <= RISE;
            y_q       <= 5'd2;
            jumping_q <= 1'b1;
          end
        end
        RISE: begin
          y_q <= (up >= {1'b0, lim}) ? lim : up[4:0];
          if (up >= {1'b0, lim}) begin
            state_q <= HOVER;
            hov_q   <= '0;
          end
        end
        HOVER: begin
          hov_q <= hov_q + 1'b1;
          if (hov_q == HW'(HOVER_FRAMES - 1)) state_q <= FALL;
        end
        FALL: begin
          y_q <= dn;
          if (y_q <= 5'd2) begin
            state_q   <= GROUND;
            jumping_q <= 1'b0;
          end
        end
        DEAD: begin
          state_q <= GROUND;
          y_q     <= '0;
        end
        default: state_q <= GROUND;
      endcase
`ifdef DOUBLE_JUMP_EN
      if (jump_req_q && !dj_used_q && (state_q == RISE || state_q == HOVER || state_q == FALL)) begin
        state_q   <= RISE;
        y_q       <= (up >= 6'(LIM2)) ? 5'(LIM2) : up[4:0];
        lim_q     <= 5'(LIM2);
        dj_used_q <= 1'b1;
        jumping_q <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: doc/rex_jump_ctrl.md
REX_JUMP_CTRL -- requirements
Module: rex_jump_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1200, clock cycles a raw button level must stay stable (10 ms) before it is accepted.
REQ-002 Parameter: JUMP_HEIGHT, 12, apex height in pixels; SHALL be even and in the range 2..14.
REQ-003 Parameter: HOVER_FRAMES, 2, frame ticks spent at the apex.
REQ-004 Port: clk_120kHz, input, 1, system clock; all flops SHALL be on its rising edge.
REQ-005 Port: rstn, input, 1, asynchronous active-low reset.
REQ-006 Port: clk_12Hz, input, 1, 12 Hz frame clock from the divider; sampled as data only.
REQ-007 Port: btn_jump, input, 1, raw asynchronous jump button, active-high.
REQ-008 Port: game_over, input, 1, collision flag from game logic, active-high, synchronous to clk_120kHz.
REQ-009 Port: frame_tick, output, 1, one-cycle pulse per frame.
REQ-010 Port: dino_y, output, 5, dino height above ground in pixels.
REQ-011 Port: jumping, output, 1, high when the state is RISE, HOVER or FALL.

Function
REQ-012 clk_12Hz and btn_jump SHALL each pass through a 2-flop synchronizer.
REQ-013 frame_tick SHALL be a registered pulse, high for exactly 1 cycle on the 3rd clock edge after clk_12Hz is first sampled high, and only once per clk_12Hz rising edge.
REQ-014 Debounce: the accepted button level SHALL update only after the synced level differs from it for DEBOUNCE_CYCLES consecutive cycles; any earlier return SHALL clear the 11-bit counter.
REQ-015 A rising edge of the accepted level SHALL set jump_req; jump_req SHALL clear at the next frame_tick whether consumed or not, so requests never queue past one frame.
REQ-016 An accepted edge in the same cycle as frame_tick SHALL set jump_req for the following frame; the current tick SHALL NOT see it.
REQ-017 FSM states: GROUND, RISE, HOVER, FALL, DEAD; transitions SHALL occur only on frame_tick, except entry into DEAD.
REQ-018 GROUND + jump_req on tick -> RISE with dino_y = 2.
REQ-019 RISE on tick: dino_y += 2; when the result is at least the limit, dino_y = limit (limit = JUMP_HEIGHT) and -> HOVER with hover count cleared.
REQ-020 HOVER on tick: hover count +1; when it reaches HOVER_FRAMES -> FALL, with dino_y unchanged.
REQ-021 FALL on tick: if dino_y is 2 or less, dino_y = 0 and -> GROUND; otherwise dino_y -= 2.
REQ-022 Without DOUBLE_JUMP_EN, jump_req while airborne SHALL be ignored.
REQ-023 game_over high SHALL force DEAD on the next clock edge from any state, with priority over ticks; dino_y SHALL be held.
REQ-024 DEAD + game_over low on tick -> GROUND, dino_y = 0, jump_req cleared.
REQ-025 dino_y arithmetic SHALL saturate within 0..31 and never wrap.

Reset
REQ-026 While rstn is low, state SHALL be GROUND and dino_y, jumping, frame_tick, jump_req, counters and synchronizers SHALL all be 0; the accepted button level SHALL be 0.
REQ-027 Reset asserted mid-jump SHALL return dino_y to 0 immediately, with no further tick needed.

Configuration
REQ-028 Macro DOUBLE_JUMP_EN defined: one extra jump per airborne period; jump_req on tick in RISE, HOVER or FALL -> RISE, limit = min(2*JUMP_HEIGHT, 30), dino_y += 2; the flag re-arms in GROUND.
REQ-029 Macro DOUBLE_JUMP_EN undefined: no double-jump logic is synthesized, the limit is constant JUMP_HEIGHT, and REQ-022 applies.

Verification
REQ-030 Defaults, btn held 1300 cycles, 12 Hz ticks -> dino_y per tick 2,4,6,8,10,12,12,12,10,8,6,4,2,0; jumping low after the final 0.
REQ-031 btn glitch high for 1000 cycles -> no jump_req, dino_y stays 0.
REQ-032 clk_12Hz rises -> frame_tick high exactly 1 cycle, 3 edges later; clk_12Hz held high 5000 cycles -> no second pulse.
REQ-033 game_over at dino_y=8 in RISE -> DEAD next cycle, dino_y 8 held; game_over low -> next tick GROUND, dino_y 0.
REQ-034 rstn low at dino_y=10 -> dino_y 0 and jumping 0 asynchronously.
REQ-035 DOUBLE_JUMP_EN, second press accepted at dino_y=12 in HOVER -> rise to 24; a third press is ignored.
